// File: rtl/word_serializer_if.sv
// Word-in / bit-out bundle of the word serializer: the producer drives the word handshake,
// the serializer drives ready, the serial bit and its framing strobes.
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic             serial;
    logic             bit_valid;
    logic             first;
    logic             last;
    logic             busy;

    modport master (
        output word, word_valid,
        input  word_ready, serial, bit_valid, first, last, busy
    );

    modport slave (
        input  word, word_valid,
        output word_ready, serial, bit_valid, first, last, busy
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial converter, MSB first; bit WIDTH-1-i appears in the cycle after accept edge + i.
// Backpressure is word_ready only: it opens in IDLE and in the final bit (GAP=0) or final gap cycle.
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    word_serializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             word_ready_q;
    logic             serial_q;
    logic             bit_valid_q;
    logic             first_q;
    logic             last_q;
    logic             busy_q;
    logic             accept;

    // word_ready is only ever high in cycles where a new word may legally start,
    // so an accept always overrides whatever the current state would do next.
    assign accept = bus.word_valid && word_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            word_ready_q <= 1'b0;
            serial_q     <= 1'b0;
            bit_valid_q  <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (accept) begin
            state        <= ST_SHIFT;
            shreg        <= bus.word;
            bit_cnt      <= CW'(WIDTH - 1);
            gap_cnt      <= '0;
            word_ready_q <= 1'b0;
            serial_q     <= bus.word[WIDTH-1];
            bit_valid_q  <= 1'b1;
            first_q      <= 1'b1;
            last_q       <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    word_ready_q <= 1'b1;
                    serial_q     <= 1'b0;
                    bit_valid_q  <= 1'b0;
                    first_q      <= 1'b0;
                    last_q       <= 1'b0;
                    busy_q       <= 1'b0;
                end
                ST_SHIFT: begin
                    if (bit_cnt != '0) begin
                        shreg        <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt      <= bit_cnt - 1'b1;
                        serial_q     <= shreg[WIDTH-2];
                        bit_valid_q  <= 1'b1;
                        first_q      <= 1'b0;
                        last_q       <= (bit_cnt == CW'(1));
                        word_ready_q <= (GAP == 0) && (bit_cnt == CW'(1));
                        busy_q       <= 1'b1;
                    end else begin
                        shreg       <= '0;
                        serial_q    <= 1'b0;
                        bit_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        last_q      <= 1'b0;
                        if (GAP > 0) begin
                            state        <= ST_GAP;
                            gap_cnt      <= GW'(GAP - 1);
                            word_ready_q <= (GAP == 1);
                            busy_q       <= 1'b1;
                        end else begin
                            state        <= ST_IDLE;
                            word_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt      <= gap_cnt - 1'b1;
                        word_ready_q <= (gap_cnt == GW'(1));
                    end else begin
                        state        <= ST_IDLE;
                        word_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    word_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_ready = word_ready_q;
    assign bus.serial     = serial_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.first      = first_q;
    assign bus.last       = last_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: a GAP=0 and a GAP=2 instance share clock and reset;
// expected bits are queued on each accept and popped as serial bits appear.
module tb_word_serializer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(8)) a ();
    word_serializer_if #(.WIDTH(8)) b ();

    word_serializer #(.WIDTH(8), .GAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(a));
    word_serializer #(.WIDTH(8), .GAP(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b));

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic push_word(input logic [7:0] w, input bit sel);
        for (int i = 7; i >= 0; i--) begin
            exp_t e;
            e.b = w[i];
            e.f = (i == 7);
            e.l = (i == 0);
            if (sel) q2.push_back(e);
            else     q0.push_back(e);
        end
    endtask

    function automatic exp_t pop0();
        if (q0.size() == 0) return 'x;
        return q0.pop_front();
    endfunction

    function automatic exp_t pop2();
        if (q2.size() == 0) return 'x;
        return q2.pop_front();
    endfunction

    function automatic logic [5:0] outs_a();
        return {a.word_ready, a.serial, a.bit_valid, a.first, a.last, a.busy};
    endfunction

    function automatic logic [5:0] outs_b();
        return {b.word_ready, b.serial, b.bit_valid, b.first, b.last, b.busy};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a.word = 8'h55; a.word_valid = 1'b1;
        b.word = 8'h55; b.word_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (outs_a() !== 6'b0) begin n_bad++; $display("FAIL reset_outs_g0 got=%b exp=000000", outs_a()); end
            n_cmp++;
            if (outs_b() !== 6'b0) begin n_bad++; $display("FAIL reset_outs_g2 got=%b exp=000000", outs_b()); end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (a.word_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge got=%b exp=0", a.word_ready); end
        @(negedge clk);
        n_cmp++;
        if (outs_a() !== 6'b100000) begin n_bad++; $display("FAIL ready_after_edge_g0 got=%b exp=100000", outs_a()); end
        n_cmp++;
        if (outs_b() !== 6'b100000) begin n_bad++; $display("FAIL ready_after_edge_g2 got=%b exp=100000", outs_b()); end
        a.word_valid = 1'b0;
        b.word_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a.bit_valid, a.busy} !== 2'b00) begin n_bad++; $display("FAIL no_early_accept got=%b exp=00", {a.bit_valid, a.busy}); end
    endtask

    task automatic test_single();
        exp_t e;
        a.word = 8'hA5; a.word_valid = 1'b1;
        n_cmp++;
        if (a.word_ready !== 1'b1) begin n_bad++; $display("FAIL single_idle_ready got=%b exp=1", a.word_ready); end
        if (a.word_ready === 1'b1) push_word(8'hA5, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) a.word_valid = 1'b0;
            e = pop0();
            n_cmp++;
            if ({a.bit_valid, a.serial, a.first, a.last} !== {1'b1, e}) begin
                n_bad++; $display("FAIL single_bit c=%0d got=%b exp=%b", c, {a.bit_valid, a.serial, a.first, a.last}, {1'b1, e});
            end
            n_cmp++;
            if (a.word_ready !== (c == 8)) begin n_bad++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, a.word_ready, (c == 8)); end
        end
        @(negedge clk);
        n_cmp++;
        if (outs_a() !== 6'b100000) begin n_bad++; $display("FAIL single_back_idle got=%b exp=100000", outs_a()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [2];
        int idx = 0;
        int rem = 0;
        exp_t e;
        w[0] = 8'h0A;
        w[1] = 8'h0F;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c <= 16) begin
                    e = pop0();
                    n_cmp++;
                    if ({a.bit_valid, a.serial, a.first, a.last} !== {1'b1, e}) begin
                        n_bad++; $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, {a.bit_valid, a.serial, a.first, a.last}, {1'b1, e});
                    end
                    if (a.bit_valid === 1'b1) rem = (rem * 2 + int'(a.serial)) % 5;
                    if (c == 8 || c == 16) begin
                        n_cmp++;
                        if (rem != 0) begin n_bad++; $display("FAIL b2b_div5 bit=%0d got=%0d exp=0", c, rem); end
                    end
                end else begin
                    n_cmp++;
                    if ({a.bit_valid, a.busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_end got=%b exp=00", {a.bit_valid, a.busy}); end
                end
            end
            if (idx < 2) begin
                a.word = w[idx];
                a.word_valid = 1'b1;
                if (a.word_ready === 1'b1) begin push_word(w[idx], 1'b0); idx++; end
            end else begin
                a.word_valid = 1'b0;
            end
        end
        n_cmp++;
        if (q0.size() != 0) begin n_bad++; $display("FAIL b2b_leftover got=%0d exp=0", q0.size()); end
    endtask

    task automatic test_gap();
        logic [7:0] w [2];
        int idx = 0;
        int gap_run = 0;
        int nbits = 0;
        bit seen_last = 1'b0;
        exp_t e;
        w[0] = 8'hC3;
        w[1] = 8'h5A;
        for (int c = 0; c <= 21; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (b.bit_valid === 1'b1) begin
                    e = pop2();
                    nbits++;
                    n_cmp++;
                    if ({b.serial, b.first, b.last} !== e) begin
                        n_bad++; $display("FAIL gap_bit c=%0d got=%b exp=%b", c, {b.serial, b.first, b.last}, e);
                    end
                    if (b.first === 1'b1 && seen_last) begin
                        n_cmp++;
                        if (gap_run != 2) begin n_bad++; $display("FAIL gap_len got=%0d exp=2", gap_run); end
                    end
                    n_cmp++;
                    if (b.word_ready !== 1'b0) begin n_bad++; $display("FAIL gap_ready_shift c=%0d got=%b exp=0", c, b.word_ready); end
                    gap_run = 0;
                    if (b.last === 1'b1) seen_last = 1'b1;
                end else begin
                    gap_run++;
                    n_cmp++;
                    if ({b.serial, b.first, b.last} !== 3'b000) begin
                        n_bad++; $display("FAIL gap_quiet c=%0d got=%b exp=000", c, {b.serial, b.first, b.last});
                    end
                    if (seen_last) begin
                        n_cmp++;
                        if (b.word_ready !== (gap_run >= 2)) begin
                            n_bad++; $display("FAIL gap_ready c=%0d got=%b exp=%b", c, b.word_ready, (gap_run >= 2));
                        end
                    end
                end
            end
            if (idx < 2) begin
                b.word = w[idx];
                b.word_valid = 1'b1;
                if (b.word_ready === 1'b1) begin push_word(w[idx], 1'b1); idx++; end
            end else begin
                b.word_valid = 1'b0;
            end
        end
        n_cmp++;
        if (nbits != 16 || q2.size() != 0) begin n_bad++; $display("FAIL gap_count got=%0d/%0d exp=16/0", nbits, q2.size()); end
        n_cmp++;
        if (b.busy !== 1'b0) begin n_bad++; $display("FAIL gap_end_busy got=%b exp=0", b.busy); end
    endtask

    task automatic test_isolation();
        exp_t e;
        a.word = 8'h3C; a.word_valid = 1'b1;
        n_cmp++;
        if (a.word_ready !== 1'b1) begin n_bad++; $display("FAIL iso_ready got=%b exp=1", a.word_ready); end
        if (a.word_ready === 1'b1) push_word(8'h3C, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin a.word = 8'hFF; a.word_valid = 1'b0; end
            e = pop0();
            n_cmp++;
            if ({a.bit_valid, a.serial, a.first, a.last} !== {1'b1, e}) begin
                n_bad++; $display("FAIL iso_bit c=%0d got=%b exp=%b", c, {a.bit_valid, a.serial, a.first, a.last}, {1'b1, e});
            end
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a.busy, a.bit_valid, a.serial} !== 3'b000) begin
                n_bad++; $display("FAIL iso_idle c=%0d got=%b exp=000", c, {a.busy, a.bit_valid, a.serial});
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        a.word = 8'hFF; a.word_valid = 1'b1;
        if (a.word_ready === 1'b1) push_word(8'hFF, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) a.word_valid = 1'b0;
            e = pop0();
            n_cmp++;
            if ({a.bit_valid, a.serial, a.first, a.last} !== {1'b1, e}) begin
                n_bad++; $display("FAIL midrst_bit c=%0d got=%b exp=%b", c, {a.bit_valid, a.serial, a.first, a.last}, {1'b1, e});
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs_a() !== 6'b0) begin n_bad++; $display("FAIL midrst_immediate got=%b exp=000000", outs_a()); end
        q0.delete();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (outs_a() !== 6'b0) begin n_bad++; $display("FAIL midrst_hold c=%0d got=%b exp=000000", c, outs_a()); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a.word_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b exp=1", a.word_ready); end
        a.word = 8'h80; a.word_valid = 1'b1;
        if (a.word_ready === 1'b1) push_word(8'h80, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) a.word_valid = 1'b0;
            e = pop0();
            n_cmp++;
            if ({a.bit_valid, a.serial, a.first, a.last} !== {1'b1, e}) begin
                n_bad++; $display("FAIL midrst_fresh c=%0d got=%b exp=%b", c, {a.bit_valid, a.serial, a.first, a.last}, {1'b1, e});
            end
        end
        @(negedge clk);
        n_cmp++;
        if (outs_a() !== 6'b100000) begin n_bad++; $display("FAIL midrst_end got=%b exp=100000", outs_a()); end
    endtask

    initial begin
        rst_n = 1'b0;
        a.word = '0; a.word_valid = 1'b0;
        b.word = '0; b.word_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_isolation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
